// File: rtl/sgpr_simx_rd_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sgpr_simx_rd_port_arbiter_pkg
//  Description : Shared constants and helpers for the SGPR read-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sgpr_simx_rd_port_arbiter_pkg;

    // One SGPR address selects a 64-bit pair (two 32-bit registers)
    localparam int SGPR_ADDR_W = 9;
    localparam int SGPR_DATA_W = 64;

    // Width of an index into n requesters; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sgpr_simx_rd_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sgpr_simx_rd_port_arbiter_if
//  Description : Requester-side and SGPR-array-side bundle of the read arbiter.
//                slave = arbiter view, master = requesters plus array view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sgpr_simx_rd_port_arbiter_if
    import sgpr_simx_rd_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int ADDR_W    = SGPR_ADDR_W,
    parameter int DATA_W    = SGPR_DATA_W
);
    logic [NUM_PORTS-1:0]        port_rd_req;
    logic [NUM_PORTS*ADDR_W-1:0] port_rd_addr;
    logic [NUM_PORTS-1:0]        port_rd_gnt;
    logic [NUM_PORTS-1:0]        port_rd_valid;
    logic [DATA_W-1:0]           port_rd_data;
    logic                        sgpr_rd_en;
    logic [ADDR_W-1:0]           sgpr_rd_addr;
    logic [DATA_W-1:0]           sgpr_rd_data;
    logic                        busy;

    modport slave (
        input  port_rd_req, port_rd_addr, sgpr_rd_data,
        output port_rd_gnt, port_rd_valid, port_rd_data,
               sgpr_rd_en, sgpr_rd_addr, busy
    );

    modport master (
        output port_rd_req, port_rd_addr, sgpr_rd_data,
        input  port_rd_gnt, port_rd_valid, port_rd_data,
               sgpr_rd_en, sgpr_rd_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/sgpr_simx_rd_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sgpr_simx_rd_port_arbiter_rr_arbiter
//  Description : Round-robin arbiter with combinational one-hot grant. The
//                search starts at the rotating pointer, which moves to the
//                port just after the winner whenever a grant is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgpr_simx_rd_port_arbiter_rr_arbiter
    import sgpr_simx_rd_port_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 8,
    localparam int c_IDX_W   = idx_width(NUM_PORTS)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [NUM_PORTS-1:0] i_req,
    output logic      [NUM_PORTS-1:0] o_gnt,
    output logic      [c_IDX_W-1:0]   o_gnt_idx
);

    logic [c_IDX_W-1:0]   r_ptr;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_found;
    int                   w_cand;

    // First requesting port at or after the pointer, wrapping around
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            w_cand = (int'(r_ptr) + off) % NUM_PORTS;
            if (!w_found && i_req[w_cand]) begin
                w_found        = 1'b1;
                w_gnt[w_cand]  = 1'b1;
                w_idx          = c_IDX_W'(w_cand);
            end
        end
    end

    // Grants are suppressed during reset so requesters never see a stale win
    assign o_gnt     = rst ? '0 : w_gnt;
    assign o_gnt_idx = w_idx;

    // Advance the pointer past the winner; hold it on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == c_IDX_W'(NUM_PORTS - 1)) ? '0 : w_idx + c_IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sgpr_simx_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sgpr_simx_rd_port_arbiter
//  Description : Arbitrates NUM_PORTS read requesters onto the single SGPR
//                read port. A one-hot tag travels alongside each read so the
//                returning data can be strobed back to its requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgpr_simx_rd_port_arbiter
    import sgpr_simx_rd_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 8,
    parameter int ADDR_W     = SGPR_ADDR_W,
    parameter int DATA_W     = SGPR_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input wire logic                     clk,
    input wire logic                     rst,
    sgpr_simx_rd_port_arbiter_if.slave   bus
);

    localparam int c_IDX_W = idx_width(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_gnt;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic [ADDR_W-1:0]    w_gnt_addr;
    logic                 w_tag_any;

    logic                 r_rd_en;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [NUM_PORTS-1:0] r_issue_tag;
    logic [NUM_PORTS-1:0] r_tag [RD_LATENCY];
    logic [NUM_PORTS-1:0] r_valid;
    logic [DATA_W-1:0]    r_data;

    sgpr_simx_rd_port_arbiter_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .i_req     (bus.port_rd_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_gnt_addr = bus.port_rd_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];

    // Issue stage: drive the array with the winner's address; address holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_issue_tag <= '0;
        end else begin
            r_rd_en     <= |w_gnt;
            r_issue_tag <= w_gnt;
            if (|w_gnt) begin
                r_rd_addr <= w_gnt_addr;
            end
        end
    end

    // Tag shift register; the last stage lines up with data leaving the array
    for (genvar s = 0; s < RD_LATENCY; s++) begin : g_tag_stage
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) r_tag[s] <= '0;
                else     r_tag[s] <= r_issue_tag;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (rst) r_tag[s] <= '0;
                else     r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // Return stage: capture array data only for a live tag, otherwise hold it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= r_tag[RD_LATENCY-1];
            if (|r_tag[RD_LATENCY-1]) begin
                r_data <= bus.sgpr_rd_data;
            end
        end
    end

    // Any tag stage still carrying a read
    always_comb begin
        w_tag_any = 1'b0;
        for (int s = 0; s < RD_LATENCY; s++) begin
            w_tag_any = w_tag_any | (|r_tag[s]);
        end
    end

    assign bus.port_rd_gnt   = w_gnt;
    assign bus.port_rd_valid = r_valid;
    assign bus.port_rd_data  = r_data;
    assign bus.sgpr_rd_en    = r_rd_en;
    assign bus.sgpr_rd_addr  = r_rd_addr;
    assign bus.busy          = (|w_gnt) | r_rd_en | (|r_issue_tag) | w_tag_any | (|r_valid);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.port_rd_gnt));
    a_valid_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.port_rd_valid));
    a_gnt_to_requester : assert property (@(posedge clk) disable iff (rst)
        (bus.port_rd_gnt & ~bus.port_rd_req) == '0);

endmodule
`default_nettype wire

// File: tb/tb_sgpr_simx_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sgpr_simx_rd_port_arbiter
//  Description : Directed bench for the SGPR read-port arbiter: one instance
//                with single-cycle array latency, one with three cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sgpr_simx_rd_port_arbiter;
    import sgpr_simx_rd_port_arbiter_pkg::*;

    localparam int NP = 8;
    localparam int AW = SGPR_ADDR_W;
    localparam int DW = SGPR_DATA_W;
    localparam int NV = 20;

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] exp_gnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    sgpr_simx_rd_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    sgpr_simx_rd_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    sgpr_simx_rd_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    sgpr_simx_rd_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)
    ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    function automatic logic [DW-1:0] arr_val(input logic [AW-1:0] a);
        logic [DW-1:0] k;
        k = {55'd0, a ^ 9'h01A};
        return 64'hDEAD_BEEF_0123_4567 ^ k ^ (k << 32);
    endfunction

    function automatic logic [AW-1:0] port_addr(input int p);
        return 9'h017 + 9'(p);
    endfunction

    function automatic int oh_idx(input logic [NP-1:0] v);
        int r = 0;
        for (int b = 0; b < NP; b++) if (v[b]) r = b;
        return r;
    endfunction

    function automatic logic [NP-1:0] g_at(input int j);
        return (j >= 0) ? vecs[j].exp_gnt : '0;
    endfunction

    // SGPR array models: unread cycles return junk so data-hold is observable
    logic [DW-1:0] arr1_q;
    logic [DW-1:0] arr3_q [3];
    always @(posedge clk) begin
        arr1_q    <= bus1.sgpr_rd_en ? arr_val(bus1.sgpr_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        arr3_q[0] <= bus3.sgpr_rd_en ? arr_val(bus3.sgpr_rd_addr) : 64'hBAD3_BAD3_BAD3_BAD3;
        arr3_q[1] <= arr3_q[0];
        arr3_q[2] <= arr3_q[1];
    end
    assign bus1.sgpr_rd_data = arr1_q;
    assign bus3.sgpr_rd_data = arr3_q[2];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic [NP-1:0] req);
        @(posedge clk);
        #1;
        bus1.port_rd_req = req;
        @(negedge clk);
    endtask

    initial begin
        logic [NP-1:0] ev;
        logic [DW-1:0] last_data;

        // Arbitration table, ports 0..7 at addresses 0x17..0x1E
        vecs[0]  = '{8'hFF, 8'h01}; vecs[1]  = '{8'hFF, 8'h02};
        vecs[2]  = '{8'hFF, 8'h04}; vecs[3]  = '{8'hFF, 8'h08};
        vecs[4]  = '{8'hFF, 8'h10}; vecs[5]  = '{8'hFF, 8'h20};
        vecs[6]  = '{8'hFF, 8'h40}; vecs[7]  = '{8'hFF, 8'h80};
        vecs[8]  = '{8'hFF, 8'h01}; vecs[9]  = '{8'h24, 8'h04};
        vecs[10] = '{8'h20, 8'h20}; vecs[11] = '{8'h00, 8'h00};
        vecs[12] = '{8'h04, 8'h04}; vecs[13] = '{8'h08, 8'h08};
        vecs[14] = '{8'h08, 8'h08}; vecs[15] = '{8'h08, 8'h08};
        vecs[16] = '{8'h00, 8'h00}; vecs[17] = '{8'h00, 8'h00};
        vecs[18] = '{8'h00, 8'h00}; vecs[19] = '{8'h00, 8'h00};

        bus1.port_rd_req  = '1;
        bus3.port_rd_req  = '1;
        bus1.port_rd_addr = '0;
        bus3.port_rd_addr = '0;
        for (int p = 0; p < NP; p++) begin
            bus1.port_rd_addr[p*AW +: AW] = port_addr(p);
            bus3.port_rd_addr[p*AW +: AW] = port_addr(p);
        end

        // Reset held three cycles with every port requesting
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset gnt c%0d", c), 64'(bus1.port_rd_gnt), '0);
            check($sformatf("reset valid c%0d", c), 64'(bus1.port_rd_valid), '0);
            check($sformatf("reset rd_en c%0d", c), 64'(bus1.sgpr_rd_en), '0);
            check($sformatf("reset busy c%0d", c), 64'(bus1.busy), '0);
            check($sformatf("reset gnt3 c%0d", c), 64'(bus3.port_rd_gnt), '0);
        end
        check("reset data", bus1.port_rd_data, '0);
        check("reset rd_addr", 64'(bus1.sgpr_rd_addr), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus1.port_rd_req = '0;
        bus3.port_rd_req = '0;

        // Table-driven run on the latency-1 instance
        last_data = '0;
        for (int i = 0; i < NV; i++) begin
            drive1(vecs[i].req);
            check($sformatf("gnt v%0d", i), 64'(bus1.port_rd_gnt), 64'(vecs[i].exp_gnt));
            check($sformatf("rd_en v%0d", i), 64'(bus1.sgpr_rd_en), 64'(|g_at(i-1)));
            if (|g_at(i-1))
                check($sformatf("rd_addr v%0d", i), 64'(bus1.sgpr_rd_addr),
                      64'(port_addr(oh_idx(g_at(i-1)))));
            ev = g_at(i-3);
            check($sformatf("valid v%0d", i), 64'(bus1.port_rd_valid), 64'(ev));
            if (|ev) last_data = arr_val(port_addr(oh_idx(ev)));
            check($sformatf("data v%0d", i), bus1.port_rd_data, last_data);
            check($sformatf("busy v%0d", i), 64'(bus1.busy),
                  64'((|g_at(i)) | (|g_at(i-1)) | (|g_at(i-2)) | (|g_at(i-3))));
        end

        // Reset one cycle after two grants: those reads must never return
        drive1(8'h01);
        check("rst-seq gnt0", 64'(bus1.port_rd_gnt), 64'h01);
        drive1(8'h02);
        check("rst-seq gnt1", 64'(bus1.port_rd_gnt), 64'h02);
        @(posedge clk);
        #1;
        bus1.port_rd_req = '0;
        rst = 1'b1;
        @(negedge clk);
        check("rst-seq gnt in rst", 64'(bus1.port_rd_gnt), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst-seq busy after", 64'(bus1.busy), '0);
        check("rst-seq rd_en after", 64'(bus1.sgpr_rd_en), '0);
        check("rst-seq data cleared", bus1.port_rd_data, '0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst-seq no valid c%0d", c), 64'(bus1.port_rd_valid), '0);
            @(negedge clk);
        end
        drive1(8'h40);
        check("rst-seq new gnt", 64'(bus1.port_rd_gnt), 64'h40);
        drive1(8'h00);
        check("rst-seq new rd_addr", 64'(bus1.sgpr_rd_addr), 64'(port_addr(6)));
        drive1(8'h00);
        drive1(8'h00);
        check("rst-seq new valid", 64'(bus1.port_rd_valid), 64'h40);
        check("rst-seq new data", bus1.port_rd_data, arr_val(port_addr(6)));

        // Latency-3 instance: four back-to-back reads, valid five cycles after gnt
        for (int c = 0; c < 10; c++) begin
            logic [NP-1:0] r;
            r = (c < 4) ? NP'(1 << c) : '0;
            @(posedge clk);
            #1;
            bus3.port_rd_req = r;
            @(negedge clk);
            check($sformatf("lat3 gnt c%0d", c), 64'(bus3.port_rd_gnt), 64'(r));
            ev = (c >= 5 && c < 9) ? NP'(1 << (c - 5)) : '0;
            check($sformatf("lat3 valid c%0d", c), 64'(bus3.port_rd_valid), 64'(ev));
            if (|ev)
                check($sformatf("lat3 data c%0d", c), bus3.port_rd_data,
                      arr_val(port_addr(c - 5)));
            check($sformatf("lat3 busy c%0d", c), 64'(bus3.busy), 64'(c < 9));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
